// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one sram_wrapper request port among NUM_CORES cores.
// Optional WAIT watchdog and sticky timeout_err port enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned NUM_CORES      = 2,
  parameter int unsigned ADDR_W         = 20,
  parameter int unsigned DATA_W         = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          is_loading_memory_into_core,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_ready,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_reset_req,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ready,
  output logic [2:0]                    grant_id,
  output logic                          busy
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  if (NUM_CORES < 1 || NUM_CORES > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: NUM_CORES must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE
  } state_e;

  state_e                 state_q;
  logic [2:0]             rr_last_q;
  logic [2:0]             grant_q;
  logic [NUM_CORES-1:0]   core_ready_q;
  logic [DATA_W-1:0]      core_rdata_q;
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q;
  logic                   mem_reset_req_q;
  logic                   busy_q;

  logic                   pick_valid_d;
  logic [2:0]             pick_id_d;
  logic                   pick_we_d;
  logic [ADDR_W-1:0]      pick_addr_d;
  logic [DATA_W-1:0]      pick_wdata_d;
  logic [NUM_CORES-1:0]   grant_onehot;
  logic                   timeout_hit;

  // rr_last + off lies in 1..2N-1, so core i is the target when the sum equals i or i+N.
  always_comb begin
    pick_valid_d = 1'b0;
    pick_id_d    = '0;
    for (int unsigned off = 1; off <= NUM_CORES; off++) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (!pick_valid_d && core_req[i] &&
            ((32'(rr_last_q) + off == i) || (32'(rr_last_q) + off == i + NUM_CORES))) begin
          pick_valid_d = 1'b1;
          pick_id_d    = 3'(i);
        end
      end
    end
    pick_we_d    = 1'b0;
    pick_addr_d  = '0;
    pick_wdata_d = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (pick_id_d == 3'(i)) begin
        pick_we_d    = core_we[i];
        pick_addr_d  = core_addr[i*ADDR_W +: ADDR_W];
        pick_wdata_d = core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      grant_onehot[i] = (grant_q == 3'(i));
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_err_q;

  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
      if (timeout_hit && !mem_ready) begin
        timeout_err_q <= 1'b1;
      end
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      rr_last_q       <= 3'(NUM_CORES - 1);
      grant_q         <= '0;
      core_ready_q    <= '0;
      core_rdata_q    <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_reset_req_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      core_ready_q    <= '0;
      mem_reset_req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid_d && !is_loading_memory_into_core) begin
            grant_q     <= pick_id_d;
            rr_last_q   <= pick_id_d;
            mem_we_q    <= pick_we_d;
            mem_addr_q  <= pick_addr_d;
            mem_wdata_q <= pick_wdata_d;
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_req_q <= 1'b1;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          // A real response wins over a watchdog expiry in the same cycle.
          if (mem_ready || timeout_hit) begin
            core_rdata_q    <= mem_ready ? mem_rdata : '0;
            mem_req_q       <= 1'b0;
            mem_reset_req_q <= 1'b1;
            core_ready_q    <= grant_onehot;
            state_q         <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign core_ready    = core_ready_q;
  assign core_rdata    = core_rdata_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_reset_req = mem_reset_req_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single sram_wrapper request port between NUM_CORES cores, as the design scales past core0.
- Sits between the core instances (is_mem_req / is_memory_we / mem_addr_out / mem_data_out ↔ data_from_mem / is_mem_ready) and sram_wrapper (requested / we / addr_in / wr_data / reset_mem_req ↔ rd_data_out / ready).
- Grants are round-robin, one outstanding transaction at a time.
- No grants are issued while the chip controller is loading memory.

Parameters:
- NUM_CORES, 2, number of requesting cores (1..8).
- ADDR_W, 20, memory address width.
- DATA_W, 128, memory line width.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-low reset.
- is_loading_memory_into_core  in  1  while high, no new grant is issued.
- core_req  in  NUM_CORES  per-core request level.
- core_we  in  NUM_CORES  per-core write enable.
- core_addr  in  NUM_CORES*ADDR_W  flattened addresses; core i occupies [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  flattened write data, same slicing as core_addr.
- core_ready  out  NUM_CORES  one-hot, one-cycle completion pulse.
- core_rdata  out  DATA_W  read data; valid in the cycle core_ready pulses.
- mem_req  out  1  to sram_wrapper requested.
- mem_we  out  1  to sram_wrapper we.
- mem_addr  out  ADDR_W  to sram_wrapper addr_in.
- mem_wdata  out  DATA_W  to sram_wrapper wr_data.
- mem_reset_req  out  1  to sram_wrapper reset_mem_req.
- mem_rdata  in  DATA_W  from sram_wrapper rd_data_out.
- mem_ready  in  1  from sram_wrapper ready.
- grant_id  out  3  index of the current or last granted core.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE.
  - All outputs 0.
  - rr_last = NUM_CORES-1, so core 0 has first priority.
- State IDLE:
  - If core_req != 0 and is_loading_memory_into_core = 0: pick the first requesting core searching from (rr_last+1) mod NUM_CORES upward with wrap.
  - Register grant_id, rr_last, and the granted core's we/addr/wdata into mem_we/mem_addr/mem_wdata.
  - Next state ISSUE.
- ISSUE: mem_req=1; next state WAIT.
- WAIT:
  - mem_req held at 1; address/data are registered and stay stable even if the core changes its inputs.
  - On mem_ready=1: capture mem_rdata into core_rdata; next state RELEASE.
- RELEASE (exactly 1 cycle):
  - mem_req=0, mem_reset_req=1, core_ready[grant_id]=1.
  - Next state IDLE.
- Latency: request seen in cycle 0 → mem_req high from cycle 2 (IDLE registers, ISSUE drives). mem_ready in cycle k → core_ready in cycle k+1 → IDLE in cycle k+2.
- Requester rules:
  - Hold core_req and its operands until its core_ready pulse.
  - Drop core_req by the cycle after the pulse.
  - The core's own is_mem_req_reset is not used; mem_reset_req is generated here.
- Fairness: with all cores requesting continuously, grants rotate 0,1,…,N-1,0. No core waits more than NUM_CORES-1 transactions.
- Loading:
  - is_loading_memory_into_core rising mid-transaction does not abort it; the transaction completes normally.
  - Only the next grant is blocked.
- Request drop: core_req falling after grant does not cancel the transaction.
- mem_ready while in IDLE, ISSUE or RELEASE is ignored.
- Mid-operation reset: the async reset returns to IDLE immediately. mem_req drops with no ready pulse; the in-flight transaction is lost.
- NUM_CORES=1 degenerates to a registered pass-through with the same timing.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- With it defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without mem_ready, go to RELEASE with core_rdata=0. core_ready still pulses and mem_reset_req pulses.
  - Sticky output port timeout_err (1 bit) is set and is cleared only by reset.
- Without it: no counter and no timeout_err port; WAIT waits indefinitely.

Test Plan:
- Single request: core0 requests a read at addr 0x00010, mem_ready 3 cycles after mem_req → mem_addr=0x00010, mem_we=0, core_ready[0] pulses once with core_rdata = mem_rdata (0xDEADBEEF…), mem_reset_req pulses in the same cycle.
- Contention: cores 0 and 1 request simultaneously from reset and keep requesting → grants 0,1,0,1; grant_id toggles; each core_ready is a single-cycle pulse.
- Write path: core1 writes addr 0xFFFFF, data 0x0123…CDEF → mem_we=1; mem_addr/mem_wdata match and stay stable for the whole WAIT even while core1 inputs change.
- Loading block: is_loading_memory_into_core=1 with core0 requesting → mem_req stays 0 and busy=0; deassert loading → mem_req rises 2 cycles later.
- Reset mid-WAIT: drop rst while in WAIT → mem_req=0 and busy=0 immediately, no core_ready pulse; the first grant after release goes to core 0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_ready never asserted → core_ready pulses with core_rdata=0 and timeout_err=1 stays set.
